univ_ff_bank: RTL and testbench

Parametrised bank of N independent flip-flop channels, each runtime-configurable as JK, SR, D or T, with a global clock enable, a registered complementary output that never lags q, per-channel change strobes and sticky SR-conflict error flags. It is the general-purpose successor to the fixed-function JK register banks, used wherever control logic needs a mixed set of set/reset, toggle and data flags behind one configuration port.

---
 rtl/univ_ff_pkg.sv | 50 +++++
 rtl/univ_ff_cell.sv | 63 ++++++
 rtl/univ_ff_bank.sv | 53 +++++
 tb/tb_univ_ff_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/univ_ff_pkg.sv
// univ_ff_pkg: shared mode encoding and next-state rules
// for the universal flip-flop bank.
package univ_ff_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

  function automatic logic next_q(
    input mode_t m,
    input logic  a,
    input logic  b,
    input logic  q
  );
    logic n;
    n = q;
    unique case (m)
      MODE_JK: begin
        case ({a, b})
          2'b01:   n = 1'b0;
          2'b10:   n = 1'b1;
          2'b11:   n = ~q;
          default: n = q;
        endcase
      end
      MODE_SR: begin
        case ({a, b})
          2'b01:   n = 1'b0;
          2'b10:   n = 1'b1;
          default: n = q;
        endcase
      end
      MODE_D:  n = a;
      MODE_T:  n = a ? ~q : q;
    endcase
    return n;
  endfunction

  function automatic logic sr_conflict(
    input mode_t m,
    input logic  a,
    input logic  b
  );
    return (m == MODE_SR) && a && b;
  endfunction

endpackage

// File: rtl/univ_ff_cell.sv
// univ_ff_cell: one runtime-configurable JK/SR/D/T channel
// with complementary output, change strobe and sticky error.
module univ_ff_cell
  import univ_ff_pkg::*;
#(
  parameter logic  RST_Q    = 1'b0,
  parameter mode_t MODE_RST = MODE_JK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       cfg_we,
  input  logic [1:0] cfg_mode,
  input  logic       err_clr,
  output logic       q,
  output logic       q_bar,
  output logic       chg,
  output logic       err,
  output logic [1:0] mode
);

  mode_t mode_q;
  logic  q_nxt;
  logic  conflict;

  always_comb begin
    q_nxt    = next_q(mode_q, a, b, q);
    conflict = en && sr_conflict(mode_q, a, b);
  end

  // q_bar is its own flop fed from the same next state,
  // so it never trails q by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= RST_Q;
      q_bar  <= ~RST_Q;
      chg    <= 1'b0;
      err    <= 1'b0;
      mode_q <= MODE_RST;
    end else begin
      if (cfg_we) begin
        mode_q <= mode_t'(cfg_mode);
      end
      if (en) begin
        q     <= q_nxt;
        q_bar <= ~q_nxt;
        chg   <= q_nxt ^ q;
      end else begin
        chg   <= 1'b0;
      end
      if (conflict) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  assign mode = mode_q;

endmodule

// File: rtl/univ_ff_bank.sv
// univ_ff_bank: N independent configurable flip-flop
// channels behind one mode-configuration port.
module univ_ff_bank
  import univ_ff_pkg::*;
#(
  parameter int          N        = 8,
  parameter logic [N-1:0] RST_VAL = {N{1'b0}},
  parameter mode_t       MODE_RST = MODE_JK,
  parameter int          IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [1:0]       cfg_mode,
  input  logic             err_clr,
  output logic [N-1:0]     q,
  output logic [N-1:0]     q_bar,
  output logic [N-1:0]     chg,
  output logic [N-1:0]     err,
  output logic [2*N-1:0]   mode
);

  logic [N-1:0] we;

  for (genvar i = 0; i < N; i++) begin : g_ch
    // Indices outside 0..N-1 match no channel and are dropped.
    assign we[i] = cfg_we && (32'(cfg_idx) == i);

    univ_ff_cell #(
      .RST_Q   (RST_VAL[i]),
      .MODE_RST(MODE_RST)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .a       (a[i]),
      .b       (b[i]),
      .cfg_we  (we[i]),
      .cfg_mode(cfg_mode),
      .err_clr (err_clr),
      .q       (q[i]),
      .q_bar   (q_bar[i]),
      .chg     (chg[i]),
      .err     (err[i]),
      .mode    (mode[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_univ_ff_bank.sv
// tb_univ_ff_bank: directed self-checking bench
// for univ_ff_bank with N=8, RST_VAL=A5.
module tb_univ_ff_bank;
  import univ_ff_pkg::*;

  localparam int N = 8;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [1:0]       cfg_mode;
  logic             err_clr;
  logic [N-1:0]     q;
  logic [N-1:0]     q_bar;
  logic [N-1:0]     chg;
  logic [N-1:0]     err;
  logic [2*N-1:0]   mode;

  int passed = 0;
  int total  = 0;

  univ_ff_bank #(
    .N       (N),
    .RST_VAL (8'hA5),
    .MODE_RST(MODE_JK),
    .IDX_W   (IDX_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a       (a),
    .b       (b),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_mode(cfg_mode),
    .err_clr (err_clr),
    .q       (q),
    .q_bar   (q_bar),
    .chg     (chg),
    .err     (err),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; a = '0; b = '0;
    cfg_we = 0; cfg_idx = '0; cfg_mode = 2'b00; err_clr = 0;
    step(); step();
    rst = 0;
    total++;
    if (q !== 8'hA5) $display("FAIL rst_q got %h want a5", q);
    else passed++;
    total++;
    if (q_bar !== 8'h5A) $display("FAIL rst_qbar got %h want 5a", q_bar);
    else passed++;
    total++;
    if (chg !== 8'h00) $display("FAIL rst_chg got %h want 00", chg);
    else passed++;
    total++;
    if (err !== 8'h00) $display("FAIL rst_err got %h want 00", err);
    else passed++;
    total++;
    if (mode !== 16'h0000) $display("FAIL rst_mode got %h want 0000", mode);
    else passed++;
    a = 8'hFF; b = 8'h0F;
    step();
    total++;
    if ({q, q_bar, chg, err} !== {8'hA5, 8'h5A, 8'h00, 8'h00})
      $display("FAIL hold_en0 got q=%h qb=%h c=%h e=%h want a5 5a 00 00",
               q, q_bar, chg, err);
    else passed++;
  endtask

  task automatic test_jk_toggle();
    logic [N-1:0] exp_q [3];
    exp_q[0] = 8'hFF; exp_q[1] = 8'h00; exp_q[2] = 8'hFF;
    en = 1; a = 8'h00; b = 8'hFF;
    step();
    total++;
    if ({q, chg} !== {8'h00, 8'hA5})
      $display("FAIL jk_clear got q=%h c=%h want 00 a5", q, chg);
    else passed++;
    a = 8'hFF; b = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({q, q_bar, chg} !== {exp_q[i], ~exp_q[i], 8'hFF})
        $display("FAIL jk_tog%0d got q=%h qb=%h c=%h want %h %h ff",
                 i, q, q_bar, chg, exp_q[i], ~exp_q[i]);
      else passed++;
    end
    en = 0; a = '0; b = '0;
  endtask

  task automatic test_sr_err();
    cfg_we = 1; cfg_idx = 4'd3; cfg_mode = MODE_SR;
    step();
    cfg_we = 0;
    total++;
    if (mode !== 16'h0040) $display("FAIL sr_mode got %h want 0040", mode);
    else passed++;
    en = 1; a = 8'h08; b = 8'h08;
    step();
    total++;
    if ({q, chg, err} !== {8'hFF, 8'h00, 8'h08})
      $display("FAIL sr_conf got q=%h c=%h e=%h want ff 00 08", q, chg, err);
    else passed++;
    err_clr = 1;
    step();
    total++;
    if (err !== 8'h08) $display("FAIL sr_setwins got %h want 08", err);
    else passed++;
    en = 0; a = '0; b = '0;
    step();
    err_clr = 0;
    total++;
    if (err !== 8'h00) $display("FAIL sr_clr got %h want 00", err);
    else passed++;
  endtask

  task automatic test_cfg_old_mode();
    en = 1; a = 8'h00; b = 8'h01;
    step();
    total++;
    if ({q, chg} !== {8'hFE, 8'h01})
      $display("FAIL cfg_pre got q=%h c=%h want fe 01", q, chg);
    else passed++;
    cfg_we = 1; cfg_idx = 4'd0; cfg_mode = MODE_D;
    a = 8'h01; b = 8'h00;
    step();
    cfg_we = 0;
    total++;
    if ({q, chg, mode} !== {8'hFF, 8'h01, 16'h0042})
      $display("FAIL cfg_old got q=%h c=%h m=%h want ff 01 0042",
               q, chg, mode);
    else passed++;
    a = 8'h00; b = 8'h00;
    step();
    total++;
    if ({q, q_bar, chg} !== {8'hFE, 8'h01, 8'h01})
      $display("FAIL cfg_dmode got q=%h qb=%h c=%h want fe 01 01",
               q, q_bar, chg);
    else passed++;
    en = 0;
    cfg_we = 1; cfg_idx = 4'd9; cfg_mode = MODE_T;
    step();
    cfg_we = 0;
    total++;
    if ({mode, q} !== {16'h0042, 8'hFE})
      $display("FAIL cfg_oob got m=%h q=%h want 0042 fe", mode, q);
    else passed++;
  endtask

  task automatic test_t_mode();
    logic       en_seq [3];
    logic [N-1:0] exp_q [3];
    logic [N-1:0] exp_c [3];
    en_seq[0] = 1; en_seq[1] = 0; en_seq[2] = 1;
    exp_q[0] = 8'hDE; exp_q[1] = 8'hDE; exp_q[2] = 8'hFE;
    exp_c[0] = 8'h20; exp_c[1] = 8'h00; exp_c[2] = 8'h20;
    cfg_we = 1; cfg_idx = 4'd5; cfg_mode = MODE_T;
    step();
    cfg_we = 0;
    total++;
    if (mode !== 16'h0C42) $display("FAIL t_mode got %h want 0c42", mode);
    else passed++;
    a = 8'h20; b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      en = en_seq[i];
      step();
      total++;
      if ({q, q_bar, chg} !== {exp_q[i], ~exp_q[i], exp_c[i]})
        $display("FAIL t_step%0d got q=%h qb=%h c=%h want %h %h %h",
                 i, q, q_bar, chg, exp_q[i], ~exp_q[i], exp_c[i]);
      else passed++;
    end
    en = 0; a = '0;
  endtask

  task automatic test_mid_reset();
    en = 1; a = 8'h08; b = 8'h08;
    step();
    total++;
    if ({q, err} !== {8'hFE, 8'h08})
      $display("FAIL mr_pre got q=%h e=%h want fe 08", q, err);
    else passed++;
    rst = 1; en = 1; a = 8'hFF; b = 8'hFF; err_clr = 0;
    cfg_we = 1; cfg_idx = 4'd1; cfg_mode = MODE_SR;
    step();
    rst = 0; cfg_we = 0; en = 0;
    total++;
    if ({q, q_bar, chg, err, mode} !==
        {8'hA5, 8'h5A, 8'h00, 8'h00, 16'h0000})
      $display("FAIL mr_vals got q=%h qb=%h c=%h e=%h m=%h want a5 5a 00 00 0000",
               q, q_bar, chg, err, mode);
    else passed++;
    step();
    total++;
    if ({q, mode} !== {8'hA5, 16'h0000})
      $display("FAIL mr_lost got q=%h m=%h want a5 0000", q, mode);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_jk_toggle();
    test_sr_err();
    test_cfg_old_mode();
    test_t_mode();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
